fe_stage_queue: RTL and testbench
=================================

Name: fe_stage_queue

Overview:
Parametrised multi-lane decoupling queue for the Qu front-end. It replaces the single-entry-per-cycle inter-stage FIFOs (IF→ID, ID→MP, MP→RN) with a queue that accepts up to WR_PORTS entries and delivers up to RD_PORTS entries per cycle. It adds a valid/ready handshake, a pipeline flush for branch/jump/exception, and exact occupancy reporting. It is instantiated once per stage boundary, with WIDTH set to the instruction width or UOP_WIDTH.

Parameters:
WIDTH, QU_INSTR_WIDTH, bits per entry
DEPTH, 12, entry count; any integer ≥ max(WR_PORTS,RD_PORTS), not necessarily a power of two
WR_PORTS, 2, enqueue lanes per cycle
RD_PORTS, 2, dequeue lanes per cycle

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
flush  in  1  discard all contents (branch/jump/exception redirect)
wr_valid  in  WR_PORTS  per-lane write request; must be a contiguous prefix from lane 0
wr_data  in  WR_PORTS*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
wr_ready  out  1  high when free slots ≥ WR_PORTS
rd_valid  out  RD_PORTS  lane i holds a valid entry
rd_data  out  RD_PORTS*WIDTH  lane i = i-th oldest entry
rd_pop  in  $clog2(RD_PORTS+1)  number of entries consumed this cycle, oldest first
count  out  $clog2(DEPTH+1)  current occupancy
empty  out  1  count==0
full  out  1  count==DEPTH
pop_err  out  1  sticky flag; set when rd_pop exceeds count

Behaviour:
- Reset (rst low, async): head=tail=count=0, pop_err=0. Outputs: rd_valid=0, rd_data=0, empty=1, full=0, wr_ready=1.
- Elaboration $error if DEPTH < WR_PORTS or DEPTH < RD_PORTS.
- Push count = number of leading set bits of wr_valid. Any wr_valid bit above the first zero is ignored.
- Enqueue is all-or-nothing: a push happens only when wr_ready=1. wr_ready depends only on registered count, with no combinational path from rd_pop.
- Entries are written at tail, tail+1, … mod DEPTH and are visible on rd_* the next cycle (1-cycle write-to-read latency).
- rd_valid[i] = (count > i). rd_data lane i = mem[(head+i) mod DEPTH], read combinationally from registered state. Invalid lanes drive 0.
- Pop count = min(rd_pop, count). head advances by the pop count mod DEPTH. If rd_pop > count, pop_err is set on the next edge and stays set until reset.
- Simultaneous push and pop: count_next = count + push − pop. Push admission uses the pre-pop free count; slots freed in the same cycle are not reused.
- Wrap-around: pointer add is (p+k ≥ DEPTH) ? p+k−DEPTH : p+k with k ≤ max ports. Correct for non-power-of-2 DEPTH.
- Flush has priority: next cycle head=tail=count=0. Same-cycle push and pop are discarded. pop_err is not cleared. wr_ready stays 1 in the cycle after flush.
- Storage is not reset and not cleared by flush; validity comes from count only.
- Reset asserted mid-operation clears state immediately, independent of clk.

Optional Feature:
Macro QU_FE_QUEUE_STATS_EN.
- Defined: adds two outputs.
  - stat_hwm [$clog2(DEPTH+1)]: maximum count observed since reset.
  - stat_stall_cycles [32]: saturating count of cycles with wr_valid[0]=1 and wr_ready=0.
  - Both are cleared by reset only; flush does not clear them.
- Undefined: the ports and logic are absent, and all other behaviour is identical.

Decomposition:
- qu_common: QU_FE_QUEUE_DEPTH, QU_FE_QUEUE_WR_PORTS, QU_FE_QUEUE_RD_PORTS default constants, plus a typedef for the queue count type.
- Sub-module ring_ptr_add (parameter DEPTH, MAX_INC): combinational modular pointer add. It is instantiated for head, tail, and each read-lane index.

Test Plan:
- Reset then push two lanes 0xA,0xB → next cycle: count=2, rd_valid=2'b11, rd_data lane0=0xA, lane1=0xB, wr_ready=1.
- DEPTH=12: push 2/cycle for 6 cycles → full=1, count=12, wr_ready=0. A further push with wr_valid=2'b11 → no change. stat_stall_cycles increments by 1 per blocked cycle.
- Wrap-around, DEPTH=5: push 2, pop 2, repeated 5× with sequential data → data order preserved. head/tail take the values 0,2,4,1,3,0.
- With count=3: push 2 and rd_pop=2 in the same cycle → count=3, and the oldest remaining entry is the 3rd one originally pushed.
- With count=7: flush together with push 2 and rd_pop=1 → next cycle count=0, empty=1, rd_valid=0, pop_err unchanged.
- With count=1: rd_pop=2 → count=0, pop_err=1 sticky. Async rst pulse mid-cycle → pop_err=0 and empty=1 before the next clk edge.

Source files
------------

// File: rtl/fe_stage_queue_pkg.sv
// Shared front-end queue defaults: entry width, depth, lane counts, count type.
package qu_common;

    localparam int QU_INSTR_WIDTH       = 32;
    localparam int QU_FE_QUEUE_DEPTH    = 12;
    localparam int QU_FE_QUEUE_WR_PORTS = 2;
    localparam int QU_FE_QUEUE_RD_PORTS = 2;
    localparam int QU_FE_QUEUE_CNT_W    = $clog2(QU_FE_QUEUE_DEPTH + 1);

    typedef logic [QU_FE_QUEUE_CNT_W-1:0] qu_fe_queue_count_t;

    // Pointer width that stays at least one bit for a single-entry ring.
    function automatic int qu_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fe_stage_queue_ring_ptr_add.sv
// Modular pointer add for a ring of DEPTH slots (any DEPTH, not only powers of two).
module ring_ptr_add
    import qu_common::*;
#(
    parameter int DEPTH   = 12,
    parameter int MAX_INC = 2,
    localparam int PW     = qu_ptr_width(DEPTH),
    localparam int IW     = $clog2(MAX_INC + 1)
) (
    input  logic [PW-1:0] ptr,
    input  logic [IW-1:0] inc,
    output logic [PW-1:0] sum
);

    // ptr < DEPTH and inc <= DEPTH, so one extra bit holds the raw sum.
    localparam int SW = PW + 1;

    logic [SW-1:0] raw;

    always_comb begin
        raw = SW'(ptr) + SW'(inc);
        if (raw >= SW'(DEPTH)) begin
            sum = PW'(raw - SW'(DEPTH));
        end else begin
            sum = PW'(raw);
        end
    end

endmodule

// File: rtl/fe_stage_queue.sv
// Multi-lane front-end decoupling queue with flush and occupancy reporting.
// Define QU_FE_QUEUE_STATS_EN to add the stat_hwm / stat_stall_cycles outputs.
module fe_stage_queue
    import qu_common::*;
#(
    parameter int WIDTH    = QU_INSTR_WIDTH,
    parameter int DEPTH    = QU_FE_QUEUE_DEPTH,
    parameter int WR_PORTS = QU_FE_QUEUE_WR_PORTS,
    parameter int RD_PORTS = QU_FE_QUEUE_RD_PORTS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [WR_PORTS-1:0]           wr_valid,
    input  logic [WR_PORTS*WIDTH-1:0]     wr_data,
    output logic                          wr_ready,
    output logic [RD_PORTS-1:0]           rd_valid,
    output logic [RD_PORTS*WIDTH-1:0]     rd_data,
    input  logic [$clog2(RD_PORTS+1)-1:0] rd_pop,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          empty,
    output logic                          full,
    output logic                          pop_err
`ifdef QU_FE_QUEUE_STATS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]    stat_hwm,
    output logic [31:0]                   stat_stall_cycles
`endif
);

    localparam int PW  = qu_ptr_width(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int RPW = $clog2(RD_PORTS + 1);
    localparam int WPW = $clog2(WR_PORTS + 1);

    if (DEPTH < WR_PORTS || DEPTH < RD_PORTS) begin : g_cfg_err
        $error("fe_stage_queue: DEPTH must be >= WR_PORTS and >= RD_PORTS");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW-1:0]  head_nx;
    logic [PW-1:0]  tail_nx;
    logic [PW-1:0]  wr_idx [WR_PORTS];
    logic [PW-1:0]  rd_idx [RD_PORTS];
    logic [WPW-1:0] lead_n;
    logic [WPW-1:0] push_n;
    logic [RPW-1:0] pop_n;
    logic [CW-1:0]  count_nx;
    logic           over_pop;
    logic           run;

    // Lanes beyond the first cleared wr_valid bit never enqueue.
    always_comb begin
        lead_n = '0;
        run    = 1'b1;
        for (int i = 0; i < WR_PORTS; i++) begin
            run = run & wr_valid[i];
            if (run) begin
                lead_n = WPW'(i + 1);
            end
        end
    end

    // Admission looks only at the registered count; same-cycle pops do not help.
    assign wr_ready = (CW'(DEPTH) - count) >= CW'(WR_PORTS);
    assign push_n   = wr_ready ? lead_n : '0;
    assign over_pop = CW'(rd_pop) > count;

    always_comb begin
        pop_n = over_pop ? RPW'(count) : rd_pop;
        if (pop_n > RPW'(RD_PORTS)) begin
            pop_n = RPW'(RD_PORTS);
        end
    end

    assign count_nx = count + CW'(push_n) - CW'(pop_n);

    ring_ptr_add #(.DEPTH(DEPTH), .MAX_INC(RD_PORTS)) u_head_add (
        .ptr (head),
        .inc (pop_n),
        .sum (head_nx)
    );

    ring_ptr_add #(.DEPTH(DEPTH), .MAX_INC(WR_PORTS)) u_tail_add (
        .ptr (tail),
        .inc (push_n),
        .sum (tail_nx)
    );

    for (genvar j = 0; j < WR_PORTS; j++) begin : g_wr_idx
        ring_ptr_add #(.DEPTH(DEPTH), .MAX_INC(WR_PORTS)) u_add (
            .ptr (tail),
            .inc (WPW'(j)),
            .sum (wr_idx[j])
        );
    end

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd_idx
        ring_ptr_add #(.DEPTH(DEPTH), .MAX_INC(RD_PORTS)) u_add (
            .ptr (head),
            .inc (RPW'(i)),
            .sum (rd_idx[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            pop_err <= 1'b0;
        end else begin
            if (over_pop) begin
                pop_err <= 1'b1;
            end
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head_nx;
                tail  <= tail_nx;
                count <= count_nx;
            end
        end
    end

    // Storage carries no reset; lane validity is derived from count alone.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int j = 0; j < WR_PORTS; j++) begin
                if (WPW'(j) < push_n) begin
                    mem[wr_idx[j]] <= wr_data[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_valid = '0;
        rd_data  = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            if (count > CW'(i)) begin
                rd_valid[i]                = 1'b1;
                rd_data[i*WIDTH +: WIDTH]  = mem[rd_idx[i]];
            end
        end
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

`ifdef QU_FE_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_hwm          <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (!flush && count_nx > stat_hwm) begin
                stat_hwm <= count_nx;
            end
            if (wr_valid[0] && !wr_ready && stat_stall_cycles != 32'hFFFF_FFFF) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fe_stage_queue.sv
// Bench for fe_stage_queue: directed scenarios plus random traffic against a queue model.
module tb_fe_stage_queue;
    import qu_common::*;

    localparam int W   = 32;
    localparam int D   = 12;
    localparam int WP  = 2;
    localparam int RP  = 2;
    localparam int CW  = $clog2(D + 1);
    localparam int D5  = 5;
    localparam int CW5 = $clog2(D5 + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    wr_valid = '0;
    logic [63:0]   wr_data = '0;
    logic [1:0]    rd_pop = '0;
    logic          wr_ready;
    logic [1:0]    rd_valid;
    logic [63:0]   rd_data;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          pop_err;
`ifdef QU_FE_QUEUE_STATS_EN
    logic [CW-1:0] stat_hwm;
    logic [31:0]   stat_stall_cycles;
`endif

    logic [1:0]     wr_valid5 = '0;
    logic [63:0]    wr_data5 = '0;
    logic [1:0]     rd_pop5 = '0;
    logic           wr_ready5;
    logic [1:0]     rd_valid5;
    logic [63:0]    rd_data5;
    logic [CW5-1:0] count5;
    logic           empty5;
    logic           full5;
    logic           pop_err5;
`ifdef QU_FE_QUEUE_STATS_EN
    logic [CW5-1:0] stat_hwm5;
    logic [31:0]    stat_stall_cycles5;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mq [$];
    bit          m_err;
    int          m_hwm;
    int          m_stall;

    always #5 clk = ~clk;

    fe_stage_queue #(.WIDTH(W), .DEPTH(D), .WR_PORTS(WP), .RD_PORTS(RP)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_pop   (rd_pop),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .pop_err  (pop_err)
`ifdef QU_FE_QUEUE_STATS_EN
        ,
        .stat_hwm          (stat_hwm),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    fe_stage_queue #(.WIDTH(W), .DEPTH(D5), .WR_PORTS(WP), .RD_PORTS(RP)) dut5 (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .wr_valid (wr_valid5),
        .wr_data  (wr_data5),
        .wr_ready (wr_ready5),
        .rd_valid (rd_valid5),
        .rd_data  (rd_data5),
        .rd_pop   (rd_pop5),
        .count    (count5),
        .empty    (empty5),
        .full     (full5),
        .pop_err  (pop_err5)
`ifdef QU_FE_QUEUE_STATS_EN
        ,
        .stat_hwm          (stat_hwm5),
        .stat_stall_cycles (stat_stall_cycles5)
`endif
    );

    task automatic model_reset();
        mq.delete();
        m_err   = 1'b0;
        m_hwm   = 0;
        m_stall = 0;
    endtask

    // Reference behaviour for one clock edge, using the inputs currently driven.
    task automatic model_step();
        int  sz;
        int  lead;
        int  np;
        bit  rdy;
        sz   = mq.size();
        rdy  = (D - sz) >= WP;
        lead = 0;
        if (wr_valid[0]) begin
            lead = 1;
            if (wr_valid[1]) lead = 2;
        end
        if (int'(rd_pop) > sz) m_err = 1'b1;
        if (wr_valid[0] && !rdy) m_stall++;
        if (flush) begin
            mq.delete();
        end else begin
            np = (int'(rd_pop) < sz) ? int'(rd_pop) : sz;
            repeat (np) void'(mq.pop_front());
            if (rdy) begin
                for (int j = 0; j < lead; j++) mq.push_back(wr_data[j*32 +: 32]);
            end
        end
        if (mq.size() > m_hwm) m_hwm = mq.size();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush    = 1'b0;
        wr_valid = 2'b00;
        rd_pop   = 2'd0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        idle_inputs();
        while (mq.size() > 0 && guard < 20) begin
            rd_pop = (mq.size() >= 2) ? 2'd2 : 2'd1;
            tick();
            guard++;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        #2;
        total++; if (count !== '0)      begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1)    begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0)     begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        total++; if (rd_valid !== 2'b00) begin bad++; $display("FAIL reset_rd_valid got=%b exp=00", rd_valid); end
        total++; if (rd_data !== 64'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        total++; if (pop_err !== 1'b0)  begin bad++; $display("FAIL reset_pop_err got=%b exp=0", pop_err); end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_basic();
        idle_inputs();
        wr_valid = 2'b11;
        wr_data  = {32'hB, 32'hA};
        tick();
        idle_inputs();
        total++; if (count !== CW'(2))   begin bad++; $display("FAIL basic_count got=%0d exp=2", count); end
        total++; if (rd_valid !== 2'b11) begin bad++; $display("FAIL basic_rd_valid got=%b exp=11", rd_valid); end
        total++; if (rd_data[31:0] !== 32'hA)  begin bad++; $display("FAIL basic_lane0 got=%h exp=a", rd_data[31:0]); end
        total++; if (rd_data[63:32] !== 32'hB) begin bad++; $display("FAIL basic_lane1 got=%h exp=b", rd_data[63:32]); end
        total++; if (wr_ready !== 1'b1)  begin bad++; $display("FAIL basic_wr_ready got=%b exp=1", wr_ready); end
        drain();
        total++; if (empty !== 1'b1)     begin bad++; $display("FAIL basic_drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full();
        logic [31:0] e0;
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            wr_valid = 2'b11;
            wr_data  = {32'h100 + 32'(2*k + 1), 32'h100 + 32'(2*k)};
            tick();
        end
        total++; if (full !== 1'b1)      begin bad++; $display("FAIL full_flag got=%b exp=1", full); end
        total++; if (count !== CW'(12))  begin bad++; $display("FAIL full_count got=%0d exp=12", count); end
        total++; if (wr_ready !== 1'b0)  begin bad++; $display("FAIL full_wr_ready got=%b exp=0", wr_ready); end
        for (int k = 0; k < 3; k++) begin
            wr_valid = 2'b11;
            wr_data  = {32'hDEAD, 32'hBEEF};
            tick();
            total++; if (count !== CW'(12)) begin bad++; $display("FAIL full_blocked_count got=%0d exp=12", count); end
            total++; if (rd_data[31:0] !== 32'h100) begin bad++; $display("FAIL full_blocked_lane0 got=%h exp=100", rd_data[31:0]); end
        end
`ifdef QU_FE_QUEUE_STATS_EN
        total++; if (stat_stall_cycles !== 32'd3) begin bad++; $display("FAIL full_stall got=%0d exp=3", stat_stall_cycles); end
        total++; if (stat_hwm !== CW'(12)) begin bad++; $display("FAIL full_hwm got=%0d exp=12", stat_hwm); end
`endif
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            e0 = 32'h100 + 32'(2*k);
            total++; if (rd_data[31:0] !== e0) begin bad++; $display("FAIL full_drain_lane0 got=%h exp=%h", rd_data[31:0], e0); end
            total++; if (rd_data[63:32] !== e0 + 32'd1) begin bad++; $display("FAIL full_drain_lane1 got=%h exp=%h", rd_data[63:32], e0 + 32'd1); end
            rd_pop = 2'd2;
            tick();
        end
        idle_inputs();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_simul();
        idle_inputs();
        wr_valid = 2'b11; wr_data = {32'hC1, 32'hC0}; tick();
        wr_valid = 2'b10; wr_data = {32'hEE, 32'hEF}; tick();
        total++; if (count !== CW'(2)) begin bad++; $display("FAIL prefix_ignore_count got=%0d exp=2", count); end
        wr_valid = 2'b01; wr_data = {32'hEE, 32'hC2}; tick();
        total++; if (count !== CW'(3)) begin bad++; $display("FAIL simul_pre_count got=%0d exp=3", count); end
        wr_valid = 2'b11; wr_data = {32'hC4, 32'hC3}; rd_pop = 2'd2; tick();
        idle_inputs();
        total++; if (count !== CW'(3)) begin bad++; $display("FAIL simul_count got=%0d exp=3", count); end
        total++; if (rd_data[31:0] !== 32'hC2)  begin bad++; $display("FAIL simul_lane0 got=%h exp=c2", rd_data[31:0]); end
        total++; if (rd_data[63:32] !== 32'hC3) begin bad++; $display("FAIL simul_lane1 got=%h exp=c3", rd_data[63:32]); end
        drain();
    endtask

    task automatic test_flush();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            wr_valid = 2'b11; wr_data = {32'h200 + 32'(2*k + 1), 32'h200 + 32'(2*k)}; tick();
        end
        wr_valid = 2'b01; wr_data = {32'h0, 32'h206}; tick();
        total++; if (count !== CW'(7)) begin bad++; $display("FAIL flush_pre_count got=%0d exp=7", count); end
        flush = 1'b1; wr_valid = 2'b11; wr_data = {32'h2FF, 32'h2FE}; rd_pop = 2'd1;
        tick();
        idle_inputs();
        total++; if (count !== '0)       begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1)     begin bad++; $display("FAIL flush_empty got=%b exp=1", empty); end
        total++; if (rd_valid !== 2'b00) begin bad++; $display("FAIL flush_rd_valid got=%b exp=00", rd_valid); end
        total++; if (pop_err !== 1'b0)   begin bad++; $display("FAIL flush_pop_err got=%b exp=0", pop_err); end
        total++; if (wr_ready !== 1'b1)  begin bad++; $display("FAIL flush_wr_ready got=%b exp=1", wr_ready); end
        wr_valid = 2'b11; wr_data = {32'h301, 32'h300}; tick();
        idle_inputs();
        total++; if (rd_data[31:0] !== 32'h300) begin bad++; $display("FAIL post_flush_lane0 got=%h exp=300", rd_data[31:0]); end
        drain();
    endtask

    task automatic test_pop_err();
        idle_inputs();
        wr_valid = 2'b01; wr_data = {32'h0, 32'h400}; tick();
        idle_inputs();
        rd_pop = 2'd2; tick();
        idle_inputs();
        total++; if (count !== '0)     begin bad++; $display("FAIL pop_err_count got=%0d exp=0", count); end
        total++; if (pop_err !== 1'b1) begin bad++; $display("FAIL pop_err_set got=%b exp=1", pop_err); end
        flush = 1'b1; tick();
        idle_inputs(); tick();
        total++; if (pop_err !== 1'b1) begin bad++; $display("FAIL pop_err_sticky got=%b exp=1", pop_err); end
        wr_valid = 2'b11; wr_data = {32'h402, 32'h401}; tick();
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        total++; if (pop_err !== 1'b0) begin bad++; $display("FAIL async_rst_pop_err got=%b exp=0", pop_err); end
        total++; if (empty !== 1'b1)   begin bad++; $display("FAIL async_rst_empty got=%b exp=1", empty); end
`ifdef QU_FE_QUEUE_STATS_EN
        total++; if (stat_stall_cycles !== 32'd0) begin bad++; $display("FAIL async_rst_stall got=%0d exp=0", stat_stall_cycles); end
        total++; if (stat_hwm !== '0) begin bad++; $display("FAIL async_rst_hwm got=%0d exp=0", stat_hwm); end
`endif
        model_reset();
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [31:0] exp_lane;
        for (int c = 0; c < 400; c++) begin
            wr_valid = 2'($urandom_range(0, 3));
            wr_data  = {$urandom(), $urandom()};
            rd_pop   = 2'($urandom_range(0, 2));
            flush    = ($urandom_range(0, 39) == 0);
            tick();
            total++; if (count !== CW'(mq.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, mq.size()); end
            total++; if (wr_ready !== ((D - mq.size()) >= WP)) begin bad++; $display("FAIL rnd_wr_ready c=%0d got=%b", c, wr_ready); end
            total++; if (pop_err !== m_err) begin bad++; $display("FAIL rnd_pop_err c=%0d got=%b exp=%b", c, pop_err, m_err); end
            total++; if (full !== (mq.size() == D)) begin bad++; $display("FAIL rnd_full c=%0d got=%b", c, full); end
            for (int i = 0; i < RP; i++) begin
                exp_lane = (i < mq.size()) ? mq[i] : 32'h0;
                total++; if (rd_valid[i] !== (i < mq.size())) begin bad++; $display("FAIL rnd_valid c=%0d lane=%0d got=%b", c, i, rd_valid[i]); end
                total++; if (rd_data[i*32 +: 32] !== exp_lane) begin bad++; $display("FAIL rnd_data c=%0d lane=%0d got=%h exp=%h", c, i, rd_data[i*32 +: 32], exp_lane); end
            end
`ifdef QU_FE_QUEUE_STATS_EN
            total++; if (stat_hwm !== CW'(m_hwm)) begin bad++; $display("FAIL rnd_hwm c=%0d got=%0d exp=%0d", c, stat_hwm, m_hwm); end
            total++; if (stat_stall_cycles !== 32'(m_stall)) begin bad++; $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, stat_stall_cycles, m_stall); end
`endif
        end
        drain();
    endtask

    task automatic test_wrap5();
        for (int k = 0; k < 5; k++) begin
            wr_valid5 = 2'b11;
            wr_data5  = {32'h500 + 32'(2*k + 1), 32'h500 + 32'(2*k)};
            @(posedge clk); #1;
            wr_valid5 = 2'b00;
            total++; if (rd_valid5 !== 2'b11) begin bad++; $display("FAIL wrap5_valid k=%0d got=%b exp=11", k, rd_valid5); end
            total++; if (rd_data5[31:0] !== 32'h500 + 32'(2*k)) begin bad++; $display("FAIL wrap5_lane0 k=%0d got=%h exp=%h", k, rd_data5[31:0], 32'h500 + 32'(2*k)); end
            total++; if (rd_data5[63:32] !== 32'h500 + 32'(2*k + 1)) begin bad++; $display("FAIL wrap5_lane1 k=%0d got=%h exp=%h", k, rd_data5[63:32], 32'h500 + 32'(2*k + 1)); end
            rd_pop5 = 2'd2;
            @(posedge clk); #1;
            rd_pop5 = 2'd0;
            total++; if (count5 !== '0) begin bad++; $display("FAIL wrap5_count k=%0d got=%0d exp=0", k, count5); end
        end
        for (int k = 0; k < 2; k++) begin
            wr_valid5 = 2'b11;
            wr_data5  = {32'h601 + 32'(2*k), 32'h600 + 32'(2*k)};
            @(posedge clk); #1;
        end
        wr_valid5 = 2'b00;
        total++; if (count5 !== CW5'(4))  begin bad++; $display("FAIL wrap5_fill_count got=%0d exp=4", count5); end
        total++; if (wr_ready5 !== 1'b0)  begin bad++; $display("FAIL wrap5_fill_wr_ready got=%b exp=0", wr_ready5); end
        total++; if (rd_data5[31:0] !== 32'h600) begin bad++; $display("FAIL wrap5_fill_lane0 got=%h exp=600", rd_data5[31:0]); end
        rd_pop5 = 2'd2;
        @(posedge clk); #1;
        total++; if (rd_data5[31:0] !== 32'h602) begin bad++; $display("FAIL wrap5_fill_lane2 got=%h exp=602", rd_data5[31:0]); end
        @(posedge clk); #1;
        rd_pop5 = 2'd0;
        total++; if (empty5 !== 1'b1) begin bad++; $display("FAIL wrap5_empty got=%b exp=1", empty5); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_simul();
        test_flush();
        test_pop_err();
        test_random();
        test_wrap5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
